bcd_display_feeder: RTL and testbench

- Upstream feeder for the 8-digit multiplexed seven-segment display.
- Accepts a binary value on a load pulse and converts it sequentially to 8 BCD digits (shift-add-3, one bit per clock); hex passthrough is also supported.
- Holds the result in a display register.
- Returns the seven-segment cathode pattern for the digit currently selected by the 3-bit seg_sel from the anode scan controller.

---
 rtl/bcd_display_feeder_pkg.sv | 67 ++++++
 rtl/bcd_display_feeder_seg7_decoder.sv | 25 ++
 rtl/bcd_display_feeder.sv | 134 +++++++++++++
 tb/tb_bcd_display_feeder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_feeder_pkg.sv
// Shared definitions for the seven-segment display feeder: FSM state encoding,
// active-low segment codes ({g,f,e,d,c,b,a}), decimal overflow limit, digit count
// and small helpers.
package bcd_display_feeder_pkg;

  typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_t;

  localparam int unsigned NumDigits = 8;
  localparam logic [31:0] DecLimit  = 32'd100_000_000;

  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegA     = 7'b0001000;
  localparam logic [6:0] SegB     = 7'b0000011;
  localparam logic [6:0] SegC     = 7'b1000110;
  localparam logic [6:0] SegD     = 7'b0100001;
  localparam logic [6:0] SegE     = 7'b0000110;
  localparam logic [6:0] SegF     = 7'b0001110;
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'b1111111;

  // Active-low glyph for one hex/BCD nibble.
  function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
    logic [6:0] pat;
    unique case (nibble)
      4'h0: pat = Seg0;
      4'h1: pat = Seg1;
      4'h2: pat = Seg2;
      4'h3: pat = Seg3;
      4'h4: pat = Seg4;
      4'h5: pat = Seg5;
      4'h6: pat = Seg6;
      4'h7: pat = Seg7;
      4'h8: pat = Seg8;
      4'h9: pat = Seg9;
      4'hA: pat = SegA;
      4'hB: pat = SegB;
      4'hC: pat = SegC;
      4'hD: pat = SegD;
      4'hE: pat = SegE;
      4'hF: pat = SegF;
    endcase
    return pat;
  endfunction

  // Blank every digit above the most significant nonzero one; digit 0 is never blanked.
  function automatic logic [7:0] lzb_mask(input logic [31:0] digits);
    logic [7:0] mask;
    logic       seen;
    mask = '0;
    seen = 1'b0;
    for (int i = NumDigits - 1; i >= 1; i--) begin
      seen    = seen | (digits[4*i +: 4] != 4'd0);
      mask[i] = ~seen;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_display_feeder_seg7_decoder.sv
// Combinational seven-segment decoder: nibble -> {g..a} plus decimal point.
// Dash overrides blank, blank overrides the glyph; active_low=0 inverts everything.
module seg7_decoder
  import bcd_display_feeder_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  input  logic       active_low,
  output logic [6:0] seg,
  output logic       dp
);

  logic [6:0] pat;

  // Select glyph, then apply output polarity.
  always_comb begin
    pat = seg_lookup(nibble);
    if (blank) pat = SegBlank;
    if (dash)  pat = SegDash;
    seg = active_low ? pat : ~pat;
    dp  = active_low;
  end

endmodule

// File: rtl/bcd_display_feeder.sv
// Display feeder: captures a binary value on load, converts it to 8 BCD digits with
// shift-add-3 (one bit per clock) or passes it through as hex nibbles, and decodes the
// digit picked by seg_sel combinationally.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_display_feeder
  import bcd_display_feeder_pkg::*;
#(
  parameter int unsigned BIN_W          = 27,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             hex_mode,
  input  logic [BIN_W-1:0] bin_in,
  input  logic [2:0]       seg_sel,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [6:0]       seg_out,
  output logic             dp
);

  localparam int unsigned CntW = 6;

  state_t           state_q, state_d;
  logic [31:0]      bcd_q, bcd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [31:0]      disp_q, disp_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       blank_q, blank_d;
  logic             done_q, done_d;
  logic [31:0]      bin_ext;
  logic [31:0]      bcd_adj;

  assign bin_ext = 32'(bin_in);

  // Add-3 correction on every BCD digit that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NumDigits; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state logic; the display register only changes in StUpdate.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    blank_d    = blank_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          ovf_pend_d = ~hex_mode & (bin_ext >= DecLimit);
          cnt_d      = '0;
          if (hex_mode) begin
            bcd_d   = bin_ext;
            state_d = StUpdate;
          end else begin
            bcd_d   = '0;
            bin_d   = bin_in;
            state_d = StConv;
          end
        end
      end
      StConv: begin
        // Top bit of the corrected BCD word falls off; only reachable on overflow.
        bcd_d = 32'({bcd_adj, bin_q[BIN_W-1]});
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(BIN_W - 1)) state_d = StUpdate;
      end
      StUpdate: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_pend_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank_d = lzb_mask(bcd_q);
`else
        blank_d = '0;
`endif
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      blank_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      blank_q    <= blank_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign ovf  = ovf_q;

  seg7_decoder u_dec (
    .nibble     (disp_q[{seg_sel, 2'b00} +: 4]),
    .blank      (blank_q[seg_sel]),
    .dash       (ovf_q),
    .active_low (SEG_ACTIVE_LOW),
    .seg        (seg_out),
    .dp         (dp)
  );

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Scoreboard bench for bcd_display_feeder: the stimulus process queues the expected
// display for every accepted load; the monitor pops on done and sweeps seg_sel.
module tb_bcd_display_feeder;

  localparam int unsigned BW     = 27;
  localparam bit          ActLow = 1'b1;

  typedef struct packed {
    logic            ovf;
    logic [7:0][6:0] seg;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic          hex_mode;
  logic [BW-1:0] bin_in;
  logic [2:0]    seg_sel;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [6:0]    seg_out;
  logic          dp;

  int   checks   = 0;
  int   failures = 0;
  int   n_done   = 0;
  int   n_acc    = 0;
  bit   chk_req  = 1'b0;
  exp_t q[$];

  bcd_display_feeder #(
    .BIN_W          (BW),
    .SEG_ACTIVE_LOW (ActLow)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .hex_mode (hex_mode),
    .bin_in   (bin_in),
    .seg_sel  (seg_sel),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .seg_out  (seg_out),
    .dp       (dp)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] glyph(input int unsigned d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;   10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Reference: digits by plain division, then glyph / dash / blank per digit.
  function automatic exp_t model(input int unsigned v, input bit hex);
    exp_t        e;
    int unsigned dig[8];
    int unsigned p;
    int          top;
    logic [6:0]  g;
    e.ovf = !hex && (v >= 100000000);
    p = 1;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      dig[i] = hex ? ((v >> (4 * i)) & 15) : ((v / p) % 10);
      p = p * 10;
      if (dig[i] != 0) top = i;
    end
    for (int i = 0; i < 8; i++) begin
      g = glyph(dig[i]);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > top) g = 7'b1111111;
`endif
      if (e.ovf) g = 7'b0111111;
      e.seg[i] = ActLow ? g : ~g;
    end
    return e;
  endfunction

  // Monitor: on done (or an explicit check request) pop one expectation and sweep digits.
  initial begin
    exp_t e;
    seg_sel = 3'd0;
    forever begin
      @(negedge clk);
      if (done || chk_req) begin
        if (done) begin
          n_done++;
          check("busy_at_done", 32'(busy), 32'd0);
        end
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty actual=output required=none");
        end else begin
          e = q.pop_front();
          check("ovf", 32'(ovf), 32'(e.ovf));
          for (int s = 0; s < 8; s++) begin
            seg_sel = 3'(s);
            #1;
            check($sformatf("seg[%0d]", s), 32'(seg_out), 32'(e.seg[s]));
            check($sformatf("dp[%0d]", s), 32'(dp), 32'(ActLow));
          end
        end
      end
    end
  end

  task automatic request_sweep(input exp_t e);
    q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1 chk_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input int unsigned v, input bit hex, input bit inject);
    int cnt;
    @(negedge clk);
    load     = 1'b1;
    hex_mode = hex;
    bin_in   = BW'(v);
    q.push_back(model(v, hex));
    n_acc++;
    @(negedge clk);
    load = 1'b0;
    cnt  = 0;
    while (busy && cnt < 200) begin
      if (inject && cnt == 5) begin
        load     = 1'b1;
        hex_mode = 1'b0;
        bin_in   = BW'(99);
      end else begin
        load = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    load = 1'b0;
    check(hex ? "busy_cycles_hex" : "busy_cycles_dec", 32'(cnt), hex ? 32'd1 : 32'(BW + 1));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned v;
    reset    = 1'b1;
    load     = 1'b0;
    hex_mode = 1'b0;
    bin_in   = '0;
    #5;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    request_sweep(model(0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    do_load(100000000, 1'b0, 1'b0);
    do_load(5, 1'b0, 1'b0);
    do_load(100000000, 1'b0, 1'b0);

    // Abort a conversion with reset: display and flags return to zero.
    @(negedge clk);
    load     = 1'b1;
    hex_mode = 1'b0;
    bin_in   = BW'(12345678);
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    request_sweep(model(0, 1'b0));
    reset = 1'b0;

    do_load(12345678, 1'b0, 1'b1);
    do_load(32'h07ABCDEF, 1'b1, 1'b0);
    do_load(42, 1'b0, 1'b0);
    do_load(0, 1'b0, 1'b0);
    do_load(0, 1'b1, 1'b0);
    do_load(99999999, 1'b0, 1'b0);
    do_load((1 << BW) - 1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom_range(0, 999);
        1:       v = $urandom_range(0, 99999999);
        default: v = $urandom & ((1 << BW) - 1);
      endcase
      do_load(v, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("done_count", 32'(n_done), 32'(n_acc));
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
